otter_iobus_timer: RTL and testbench



---
 rtl/otter_io_pkg.sv | 21 ++
 rtl/otter_timer_prescaler.sv | 35 +++
 rtl/otter_iobus_timer.sv | 134 +++++++++++++
 tb/tb_otter_iobus_timer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: timer register offsets and CTRL layout.
package otter_io_pkg;

  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_LOAD   = 3'd1;
  localparam logic [2:0] TMR_COUNT  = 3'd2;
  localparam logic [2:0] TMR_STATUS = 3'd3;
  localparam logic [2:0] TMR_PRESC  = 3'd4;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // Member order matches the CTRL bit indices (first member is the MSB).
  typedef struct packed {
    logic irq_en;
    logic reload;
    logic en;
  } tmr_ctrl_t;

endpackage

// File: rtl/otter_timer_prescaler.sv
// Prescale counter for the IOBUS timer: emits one tick every (presc + 1) enabled cycles.
module otter_timer_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               wrap;

  // >= rather than == so that shrinking presc mid-period ends the period at once.
  assign wrap = (pcnt_q >= presc);
  assign tick = en & wrap;

  always_comb begin
    pcnt_d = pcnt_q + PRESC_W'(1);
    if (!en || clr || wrap) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped down-counter timer on the OTTER IOBUS with one-cycle read latency and a
// level interrupt on expiry.
module otter_iobus_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR,
  output logic        hit
);

  tmr_ctrl_t          ctrl_q, ctrl_d;
  logic [31:0]        load_q, load_d;
  logic [31:0]        count_q, count_d;
  logic               exp_q, exp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        rdata_q, rdata;
  logic               hit_q;

  logic       sel;
  logic [2:0] offset;
  logic       wr_ctrl, wr_load, wr_status, wr_presc;
  logic       tick, tick_eff, expire, pcnt_clr;
  logic       unused_addr_lsb;

  assign sel             = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign offset          = IOBUS_ADDR[4:2];
  assign unused_addr_lsb = ^IOBUS_ADDR[1:0];

  assign wr_ctrl   = IOBUS_WR & sel & (offset == TMR_CTRL);
  assign wr_load   = IOBUS_WR & sel & (offset == TMR_LOAD);
  assign wr_status = IOBUS_WR & sel & (offset == TMR_STATUS);
  assign wr_presc  = IOBUS_WR & sel & (offset == TMR_PRESC);

  // Restart the prescale period on a LOAD write or a fresh enable.
  assign pcnt_clr = wr_load | (wr_ctrl & IOBUS_OUT[CTRL_EN] & ~ctrl_q.en);

  otter_timer_prescaler #(
    .PRESC_W(PRESC_W)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (ctrl_q.en),
    .clr  (pcnt_clr),
    .presc(presc_q),
    .tick (tick)
  );

  // A LOAD write or a disabling CTRL write swallows the tick of the same cycle.
  assign tick_eff = tick & ~wr_load & ~(wr_ctrl & ~IOBUS_OUT[CTRL_EN]);
  assign expire   = tick_eff & (count_q == '0);

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    presc_d = presc_q;

    if (tick_eff) begin
      if (!expire) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q.reload) begin
        count_d = load_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end

    if (wr_ctrl) begin
      ctrl_d = tmr_ctrl_t'(IOBUS_OUT[2:0]);
    end
    if (wr_load) begin
      load_d  = IOBUS_OUT;
      count_d = IOBUS_OUT;
    end
    if (wr_status && IOBUS_OUT[0]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
    if (wr_presc) begin
      presc_d = IOBUS_OUT[PRESC_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      TMR_CTRL:   rdata = 32'(ctrl_q);
      TMR_LOAD:   rdata = load_q;
      TMR_COUNT:  rdata = count_q;
      TMR_STATUS: rdata = {31'd0, exp_q};
      TMR_PRESC:  rdata = 32'(presc_q);
      default:    rdata = '0;
    endcase
    if (!sel) begin
      rdata = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
      presc_q <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      presc_q <= presc_d;
      rdata_q <= rdata;
      hit_q   <= sel;
    end
  end

  assign IOBUS_IN = rdata_q;
  assign hit      = hit_q;
  assign INTR     = exp_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: directed scenarios plus randomized timing runs
// checked against closed-form tick/count arithmetic.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE     = 32'h1100_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0c;
  localparam logic [31:0] A_PRESC  = BASE + 32'h10;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        INTR;
  logic        hit;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  otter_iobus_timer #(
    .BASE_ADDR(BASE),
    .PRESC_W  (16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .INTR      (INTR),
    .hit       (hit)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: with the timer enabled in cycle 0 and pcnt at 0, tick number j (1-based)
  // lands in cycle j*(p+1)-1, so ticks strictly before cycle k number k/(p+1).
  function automatic int n_ticks(int k, int p);
    return (k <= 0) ? 0 : k / (p + 1);
  endfunction

  function automatic logic [31:0] model_count(int k, int p, int l, bit rl);
    int j;
    j = n_ticks(k, p);
    if (rl) return 32'(l - (j % (l + 1)));
    return (j >= l) ? 32'd0 : 32'(l - j);
  endfunction

  // First expiry is tick l+1 in both modes; EXP is sticky afterwards.
  function automatic bit model_exp(int k, int p, int l);
    return n_ticks(k, p) >= l + 1;
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic h);
    IOBUS_ADDR = addr;
    IOBUS_WR   = 1'b0;
    @(negedge CLK);
    data = IOBUS_IN;
    h    = hit;
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = BASE;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    do_reset();
    total++;
    if (IOBUS_IN !== 32'd0 || hit !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus: got in=%h hit=%b want in=0 hit=0", IOBUS_IN, hit);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'(4 * i), d, h);
      total++;
      if (d !== 32'd0 || h !== 1'b1 || INTR !== 1'b0) begin
        bad++;
        $display("FAIL reset_reg%0d: got d=%h hit=%b intr=%b want 0 1 0", i, d, h, INTR);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        h;
    int          base;
    do_reset();
    bus_write(A_PRESC, 32'd0);
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'b101);
    base       = cyc;
    IOBUS_ADDR = A_COUNT;
    for (int m = 0; m < 7; m++) begin
      @(negedge CLK);
      total++;
      if (IOBUS_IN !== model_count(cyc - base - 1, 0, 3, 1'b0)) begin
        bad++;
        $display("FAIL oneshot_count k=%0d: got %0d want %0d", cyc - base - 1, IOBUS_IN,
                 model_count(cyc - base - 1, 0, 3, 1'b0));
      end
      total++;
      if (INTR !== model_exp(cyc - base, 0, 3)) begin
        bad++;
        $display("FAIL oneshot_intr k=%0d: got %b want %b", cyc - base, INTR,
                 model_exp(cyc - base, 0, 3));
      end
    end
    bus_read(A_CTRL, d, h);
    total++;
    if (d !== 32'h4) begin
      bad++;
      $display("FAIL oneshot_ctrl: got %h want 4", d);
    end
    bus_read(A_STATUS, d, h);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL oneshot_status: got %h want 1", d);
    end
  endtask

  task automatic test_reload();
    int base;
    int kw;
    int j;
    do_reset();
    bus_write(A_PRESC, 32'd2);
    bus_write(A_LOAD, 32'd1);
    bus_write(A_CTRL, 32'b111);
    base       = cyc;
    IOBUS_ADDR = A_COUNT;
    for (int m = 0; m < 15; m++) begin
      @(negedge CLK);
      total++;
      if (IOBUS_IN !== model_count(cyc - base - 1, 2, 1, 1'b1)) begin
        bad++;
        $display("FAIL reload_count k=%0d: got %0d want %0d", cyc - base - 1, IOBUS_IN,
                 model_count(cyc - base - 1, 2, 1, 1'b1));
      end
      total++;
      if (INTR !== model_exp(cyc - base, 2, 1)) begin
        bad++;
        $display("FAIL reload_intr k=%0d: got %b want %b", cyc - base, INTR,
                 model_exp(cyc - base, 2, 1));
      end
    end
    // Clear EXP in a cycle with no tick at all.
    while ((cyc - base) % 3 != 0) @(negedge CLK);
    kw = cyc - base;
    bus_write(A_STATUS, 32'd1);
    total++;
    if (INTR !== 1'b0) begin
      bad++;
      $display("FAIL reload_clear: got intr=%b want 0", INTR);
    end
    j = kw / 3 + 1;
    if (j % 2 != 0) j++;
    while (cyc - base < 3 * j - 1) @(negedge CLK);
    total++;
    if (INTR !== 1'b0) begin
      bad++;
      $display("FAIL reload_pre_reexp: got intr=%b want 0", INTR);
    end
    @(negedge CLK);
    total++;
    if (INTR !== 1'b1) begin
      bad++;
      $display("FAIL reload_reexp: got intr=%b want 1", INTR);
    end
  endtask

  task automatic test_collisions();
    logic [31:0] d;
    logic        h;
    // STATUS clear lands on the expiry tick (cycle 2).
    do_reset();
    bus_write(A_PRESC, 32'd0);
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'b111);
    repeat (2) @(negedge CLK);
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, d, h);
    total++;
    if (d !== 32'd1 || INTR !== 1'b1) begin
      bad++;
      $display("FAIL coll_status_clear: got exp=%h intr=%b want 1 1", d, INTR);
    end
    // LOAD write lands on a tick (cycle 2 with PRESC=2).
    do_reset();
    bus_write(A_PRESC, 32'd2);
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'b001);
    repeat (2) @(negedge CLK);
    bus_write(A_LOAD, 32'd5);
    bus_read(A_COUNT, d, h);
    total++;
    if (d !== 32'd5) begin
      bad++;
      $display("FAIL coll_load_tick: got count=%0d want 5", d);
    end
    bus_read(A_STATUS, d, h);
    total++;
    if (d !== 32'd0) begin
      bad++;
      $display("FAIL coll_load_noexp: got exp=%h want 0", d);
    end
    // Disabling CTRL write lands on a tick: that tick is dropped.
    do_reset();
    bus_write(A_PRESC, 32'd0);
    bus_write(A_LOAD, 32'd4);
    bus_write(A_CTRL, 32'b001);
    @(negedge CLK);
    bus_write(A_CTRL, 32'b000);
    bus_read(A_COUNT, d, h);
    total++;
    if (d !== 32'd3) begin
      bad++;
      $display("FAIL coll_disable_tick: got count=%0d want 3", d);
    end
    // CTRL write races the one-shot auto-clear of EN: the write wins.
    do_reset();
    bus_write(A_PRESC, 32'd0);
    bus_write(A_LOAD, 32'd0);
    bus_write(A_CTRL, 32'b001);
    bus_write(A_CTRL, 32'b001);
    bus_read(A_CTRL, d, h);
    total++;
    if (d !== 32'd1) begin
      bad++;
      $display("FAIL coll_ctrl_autoclr: got ctrl=%h want 1", d);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic        h;
    logic [31:0] want [5];
    do_reset();
    bus_write(A_LOAD, 32'h1234);
    bus_write(BASE + 32'h20, 32'hdead_beef);
    bus_write(A_COUNT, 32'hdead_beef);
    want = '{32'd0, 32'h1234, 32'h1234, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 32'(4 * i), d, h);
      total++;
      if (d !== want[i]) begin
        bad++;
        $display("FAIL decode_reg%0d: got %h want %h", i, d, want[i]);
      end
    end
    bus_read(BASE + 32'h20, d, h);
    total++;
    if (d !== 32'd0 || h !== 1'b0) begin
      bad++;
      $display("FAIL decode_outside: got d=%h hit=%b want 0 0", d, h);
    end
    bus_read(BASE + 32'h14, d, h);
    total++;
    if (d !== 32'd0 || h !== 1'b1) begin
      bad++;
      $display("FAIL decode_hole: got d=%h hit=%b want 0 1", d, h);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] d;
    logic        h;
    int          base;
    do_reset();
    bus_write(A_PRESC, 32'd3);
    bus_write(A_LOAD, 32'd20);
    bus_write(A_CTRL, 32'b111);
    base = cyc;
    while (cyc - base < 52) @(negedge CLK);
    bus_read(A_COUNT, d, h);
    total++;
    if (d !== 32'd7) begin
      bad++;
      $display("FAIL midreset_pre: got count=%0d want 7", d);
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    total++;
    if (INTR !== 1'b0 || IOBUS_IN !== 32'd0 || hit !== 1'b0) begin
      bad++;
      $display("FAIL midreset_out: got intr=%b in=%h hit=%b want 0 0 0", INTR, IOBUS_IN, hit);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 32'(4 * i), d, h);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL midreset_reg%0d: got %h want 0", i, d);
      end
    end
    repeat (20) @(negedge CLK);
    bus_read(A_COUNT, d, h);
    total++;
    if (d !== 32'd0 || INTR !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle: got count=%h intr=%b want 0 0", d, INTR);
    end
  endtask

  task automatic test_random();
    int p, l, base;
    bit rl;
    for (int it = 0; it < 6; it++) begin
      p  = int'($urandom_range(0, 3));
      l  = int'($urandom_range(0, 5));
      rl = 1'($urandom_range(0, 1));
      do_reset();
      bus_write(A_PRESC, 32'(p));
      bus_write(A_LOAD, 32'(l));
      bus_write(A_CTRL, {29'd0, 1'b1, rl, 1'b1});
      base       = cyc;
      IOBUS_ADDR = A_COUNT;
      for (int m = 0; m < 24; m++) begin
        @(negedge CLK);
        total++;
        if (IOBUS_IN !== model_count(cyc - base - 1, p, l, rl)) begin
          bad++;
          $display("FAIL rand_count p=%0d l=%0d rl=%0d k=%0d: got %0d want %0d", p, l, rl,
                   cyc - base - 1, IOBUS_IN, model_count(cyc - base - 1, p, l, rl));
        end
        total++;
        if (INTR !== model_exp(cyc - base, p, l)) begin
          bad++;
          $display("FAIL rand_intr p=%0d l=%0d rl=%0d k=%0d: got %b want %b", p, l, rl,
                   cyc - base, INTR, model_exp(cyc - base, p, l));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    RESET      = 1'b1;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    @(negedge CLK);
    test_reset();
    test_oneshot();
    test_reload();
    test_collisions();
    test_decode();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
